// File: rtl/sram_like_responder_if.sv
// sram_like_responder_if: bundle for the sram-like req/addr_ok/data_ok bus.
// master issues requests; slave accepts them and returns data_ok/rdata in order.
interface sram_like_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_responder.sv
// sram_like_responder: word RAM target answering pipelined sram-like requests in order.
// Define SRAM_RAND_DELAY_EN for LFSR-driven accept gating and 0-3 cycles of extra latency.
module sram_like_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int MAX_OUTST  = 2,
    parameter int RESP_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_like_responder_if.slave bus
);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int WW = $clog2(RESP_LAT + 4);

    logic [31:0]           mem    [2**DEPTH_LOG2];
    logic [31:0]           q_data [2**PW];
    logic [WW-1:0]         q_wait [2**PW];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_nxt;
    logic [CW-1:0]         count;
    logic [CW-1:0]         remain;
    logic [CW-1:0]         count_nxt;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  gate;
    logic                  push;
    logic                  pop;
    logic                  head_ready;
    logic                  data_ok_q;
    logic [1:0]            extra;
    logic [WW-1:0]         wait_new;
    logic [31:0]           resp;
    logic [31:0]           head_data;
    logic [31:0]           rdata_q;
    logic                  unused_bits;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef SRAM_RAND_DELAY_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= 16'hACE1;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign gate  = ~lfsr[0];
    assign extra = lfsr[2:1];
`else
    assign gate  = 1'b1;
    assign extra = 2'd0;
`endif

    assign unused_bits = ^{bus.size, bus.addr[31:DEPTH_LOG2+2], bus.addr[1:0]};

    assign idx         = bus.addr[DEPTH_LOG2+1:2];
    assign bus.addr_ok = bus.req & ~reset & gate & (count < CW'(MAX_OUTST));
    assign push        = bus.addr_ok;
    assign resp        = bus.wr ? 32'd0 : mem[idx];
    assign wait_new    = WW'(RESP_LAT - 1) + WW'(extra);
    assign bus.data_ok = data_ok_q;
    assign bus.rdata   = rdata_q;

    // The entry shown on data_ok stays counted until the edge that ends that cycle.
    always_comb begin
        pop       = data_ok_q;
        rd_nxt    = pop ? inc(rd_ptr) : rd_ptr;
        remain    = count - CW'(pop);
        count_nxt = remain + CW'(push);
        if (remain == '0) begin
            head_ready = push && (wait_new == '0);
            head_data  = resp;
        end else begin
            head_ready = q_wait[rd_nxt] <= WW'(1);
            head_data  = q_data[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rd_ptr    <= rd_nxt;
            count     <= count_nxt;
            data_ok_q <= (count_nxt != '0) && head_ready;
            if (push)
                wr_ptr <= inc(wr_ptr);
            if ((count_nxt != '0) && head_ready)
                rdata_q <= head_data;
        end
    end

    // Wait counters keep running behind a stalled head so followers drain back-to-back.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2**PW; i++) begin
            if (push && (wr_ptr == PW'(i))) begin
                q_data[i] <= resp;
                q_wait[i] <= wait_new;
            end else if (q_wait[i] != '0) begin
                q_wait[i] <= q_wait[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && bus.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b])
                    mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end
endmodule
